// File: rtl/uart_rx_fifo.sv
// UART receiver with 2-of-3 majority bit voting, optional parity, one or two
// stop bits, break detection and a first-word-fall-through receive FIFO.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | line idle, waiting for a tick that sees the line low
//   S_START  | start bit; a vote of 1 is treated as a glitch and abandoned
//   S_DATA   | DATA_WIDTH data bits, LSB first
//   S_PARITY | parity bit (only when parity is enabled for this frame)
//   S_STOP1  | first stop bit; the word is pushed here unless two stop bits
//   S_STOP2  | second stop bit; the word is pushed at its decision tick
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int OVS_RATE   = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_rx,
    input  logic [DIV_WIDTH-1:0]          i_baud_div,
    input  logic [1:0]                    i_parity_mode,
    input  logic                          i_stop2,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_perr,
    output logic                          o_ferr,
    output logic                          o_brk,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_overrun,
    input  logic                          i_clr_overrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TW    = $clog2(OVS_RATE);
    localparam int BW    = $clog2(DATA_WIDTH);
    localparam int WW    = DATA_WIDTH + 3;

    localparam logic [TW-1:0]    T_S0     = TW'(OVS_RATE / 2 - 1);
    localparam logic [TW-1:0]    T_S1     = TW'(OVS_RATE / 2);
    localparam logic [TW-1:0]    T_S2     = TW'(OVS_RATE / 2 + 1);
    localparam logic [TW-1:0]    T_LAST   = TW'(OVS_RATE - 1);
    localparam logic [BW-1:0]    B_LAST   = BW'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_t;

    logic                  sync1_q, sync2_q, rx_s;
    logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d, eff_div, div_m1;
    logic                  tick;

    state_t                state_q, state_d;
    logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [1:0]            samp_q, samp_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_q, par_d;
    logic                  stop1_q, stop1_d;
    logic [DIV_WIDTH-1:0]  div_lat_q, div_lat_d;
    logic [1:0]            pmode_q, pmode_d;
    logic                  stop2_lat_q, stop2_lat_d;
    logic                  brk_hold_q, brk_hold_d;

    logic                  vote, par_en, stop1_v;
    logic                  push;
    logic [WW-1:0]         push_word;

    logic [WW-1:0]         mem_q [FIFO_DEPTH];
    logic [WW-1:0]         mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic                  do_pop, full, push_ok, ovr_set;
    logic [WW-1:0]         head;

    // Two-flop synchronizer, preset high so a released line never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_rx;
            sync2_q <= sync1_q;
        end
    end
    assign rx_s = sync2_q;

    // Free-running oversample tick; the divisor is frozen while a frame is in flight.
    always_comb begin
        eff_div   = (state_q == S_IDLE) ? i_baud_div : div_lat_q;
        div_m1    = (eff_div == '0) ? '0 : eff_div - DIV_WIDTH'(1);
        tick      = (div_cnt_q >= div_m1);
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_WIDTH'(1);
    end

    // Receive FSM: next state, bit sampling, majority vote and word assembly.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        samp_d      = samp_q;
        data_d      = data_q;
        par_d       = par_q;
        stop1_d     = stop1_q;
        div_lat_d   = div_lat_q;
        pmode_d     = pmode_q;
        stop2_lat_d = stop2_lat_q;
        brk_hold_d  = brk_hold_q & ~rx_s;
        push        = 1'b0;

        vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
        par_en  = (pmode_q == 2'b01) || (pmode_q == 2'b10);
        stop1_v = (state_q == S_STOP1) ? vote : stop1_q;

        // A break holds the receiver off until the line has gone high again.
        push_word[DATA_WIDTH-1:0] = data_q;
        push_word[DATA_WIDTH]     = par_en & (^data_q ^ par_q ^ (pmode_q == 2'b10));
        push_word[DATA_WIDTH+1]   = ~stop1_v | ((state_q == S_STOP2) & ~vote);
        push_word[DATA_WIDTH+2]   = (data_q == '0) & ~(par_en & par_q) & ~stop1_v;

        if (tick) begin
            if (state_q == S_IDLE) begin
                if (!rx_s && !brk_hold_q) begin
                    state_d     = S_START;
                    tick_cnt_d  = TW'(1);
                    bit_cnt_d   = '0;
                    div_lat_d   = i_baud_div;
                    pmode_d     = i_parity_mode;
                    stop2_lat_d = i_stop2;
                end
            end else begin
                tick_cnt_d = (tick_cnt_q == T_LAST) ? '0 : tick_cnt_q + TW'(1);
                if (tick_cnt_q == T_S0) samp_d[0] = rx_s;
                if (tick_cnt_q == T_S1) samp_d[1] = rx_s;
                case (state_q)
                    S_START: begin
                        if (tick_cnt_q == T_S2 && vote) begin
                            state_d    = S_IDLE;
                            tick_cnt_d = '0;
                        end else if (tick_cnt_q == T_LAST) begin
                            state_d = S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (tick_cnt_q == T_S2) data_d = {vote, data_q[DATA_WIDTH-1:1]};
                        if (tick_cnt_q == T_LAST) begin
                            if (bit_cnt_q == B_LAST) begin
                                bit_cnt_d = '0;
                                state_d   = par_en ? S_PARITY : S_STOP1;
                            end else begin
                                bit_cnt_d = bit_cnt_q + BW'(1);
                            end
                        end
                    end
                    S_PARITY: begin
                        if (tick_cnt_q == T_S2) par_d = vote;
                        if (tick_cnt_q == T_LAST) state_d = S_STOP1;
                    end
                    S_STOP1: begin
                        if (tick_cnt_q == T_S2) begin
                            stop1_d = vote;
                            if (!stop2_lat_q) begin
                                push       = 1'b1;
                                state_d    = S_IDLE;
                                tick_cnt_d = '0;
                            end
                        end else if (tick_cnt_q == T_LAST) begin
                            state_d = S_STOP2;
                        end
                    end
                    S_STOP2: begin
                        if (tick_cnt_q == T_S2) begin
                            push       = 1'b1;
                            state_d    = S_IDLE;
                            tick_cnt_d = '0;
                        end
                    end
                    default: begin
                        state_d    = S_IDLE;
                        tick_cnt_d = '0;
                    end
                endcase
                if (push && push_word[DATA_WIDTH+2]) brk_hold_d = 1'b1;
            end
        end
    end

    // FIFO pointer, occupancy, storage and sticky overrun next-state.
    always_comb begin
        do_pop  = (count_q != '0) && i_ready;
        full    = (count_q == CNT_FULL);
        push_ok = push && (!full || do_pop);
        ovr_set = push && full && !do_pop;
        wr_d    = wr_q + PTR_W'(push_ok);
        rd_d    = rd_q + PTR_W'(do_pop);
        count_d = count_q;
        if (push_ok && !do_pop) count_d = count_q + CNT_W'(1);
        if (!push_ok && do_pop) count_d = count_q - CNT_W'(1);
        mem_d = mem_q;
        if (push_ok) mem_d[wr_q] = push_word;
        overrun_d = ovr_set ? 1'b1 : (i_clr_overrun ? 1'b0 : overrun_q);
    end

    // Control and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q   <= '0;
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            samp_q      <= '0;
            data_q      <= '0;
            par_q       <= 1'b0;
            stop1_q     <= 1'b0;
            div_lat_q   <= '0;
            pmode_q     <= 2'b00;
            stop2_lat_q <= 1'b0;
            brk_hold_q  <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            samp_q      <= samp_d;
            data_q      <= data_d;
            par_q       <= par_d;
            stop1_q     <= stop1_d;
            div_lat_q   <= div_lat_d;
            pmode_q     <= pmode_d;
            stop2_lat_q <= stop2_lat_d;
            brk_hold_q  <= brk_hold_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
        end
    end

    // FIFO storage needs no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign o_valid   = (count_q != '0);
    assign head      = o_valid ? mem_q[rd_q] : '0;
    assign o_data    = head[DATA_WIDTH-1:0];
    assign o_perr    = head[DATA_WIDTH];
    assign o_ferr    = head[DATA_WIDTH+1];
    assign o_brk     = head[DATA_WIDTH+2];
    assign o_count   = count_q;
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at default parameters, baud divisor 4.
module tb_uart_rx_fifo;

    localparam int DIV = 4;
    localparam int BIT = DIV * 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_rx;
    logic [15:0] i_baud_div;
    logic [1:0]  i_parity_mode;
    logic        i_stop2;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_data;
    logic        o_perr, o_ferr, o_brk;
    logic [4:0]  o_count;
    logic        o_overrun;
    logic        i_clr_overrun;

    int tests = 0;
    int fails = 0;
    logic [10:0] exp_q [$];

    uart_rx_fifo dut (
        .clk(clk), .rst(rst), .i_rx(i_rx), .i_baud_div(i_baud_div),
        .i_parity_mode(i_parity_mode), .i_stop2(i_stop2),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_perr(o_perr), .o_ferr(o_ferr), .o_brk(o_brk),
        .o_count(o_count), .o_overrun(o_overrun), .i_clr_overrun(i_clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic brk, input logic ferr,
                                       input logic perr, input logic [7:0] d);
        return {brk, ferr, perr, d};
    endfunction

    // Monitor: every accepted head word is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got 0x%0h expected none",
                         {o_brk, o_ferr, o_perr, o_data});
            end else begin
                chk("sb_word", {21'd0, o_brk, o_ferr, o_perr, o_data}, {21'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                              input int nstop, input logic s1, input logic s2);
        logic [15:0] bits;
        int n;
        bits = '1;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin bits[n] = d[i]; n++; end
        if (par_en) begin bits[n] = par_bit; n++; end
        bits[n] = s1; n++;
        if (nstop == 2) begin bits[n] = s2; n++; end
        for (int i = 0; i < n; i++) begin
            i_rx = bits[i];
            repeat (BIT) @(negedge clk);
        end
        i_rx = 1'b1;
    endtask

    task automatic gap(input int nbits);
        i_rx = 1'b1;
        repeat (nbits * BIT) @(negedge clk);
    endtask

    task automatic wait_drain();
        int budget;
        i_ready = 1'b1;
        budget = 400;
        while (o_count != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: count %0d expected 0", o_count);
        end
        repeat (2) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; i_rx = 1'b1; i_baud_div = 16'(DIV); i_parity_mode = 2'b00;
        i_stop2 = 1'b0; i_ready = 1'b0; i_clr_overrun = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_count", o_count, 0);
        chk("rst_overrun", o_overrun, 0);
        chk("rst_head", {o_brk, o_ferr, o_perr, o_data}, 0);

        // 8N1 0xA5, held in the FIFO to observe occupancy
        exp_q.push_back(mk(0, 0, 0, 8'hA5));
        send_frame(8'hA5, 0, 0, 1, 1, 0);
        gap(2);
        chk("a5_count", o_count, 1);
        chk("a5_valid", o_valid, 1);
        wait_drain();

        // parity: even then odd, then mode 11 treated as none
        i_ready = 1'b1;
        i_parity_mode = 2'b01;
        exp_q.push_back(mk(0, 0, 1, 8'h07)); send_frame(8'h07, 1, 0, 1, 1, 0); gap(1);
        exp_q.push_back(mk(0, 0, 0, 8'h07)); send_frame(8'h07, 1, 1, 1, 1, 0); gap(1);
        i_parity_mode = 2'b10;
        exp_q.push_back(mk(0, 0, 0, 8'h07)); send_frame(8'h07, 1, 0, 1, 1, 0); gap(1);
        exp_q.push_back(mk(0, 0, 1, 8'h07)); send_frame(8'h07, 1, 1, 1, 1, 0); gap(1);
        i_parity_mode = 2'b11;
        exp_q.push_back(mk(0, 0, 0, 8'h81)); send_frame(8'h81, 0, 0, 1, 1, 0); gap(1);
        i_parity_mode = 2'b00;
        wait_drain();

        // short low glitch: no push, receiver still ready for a real frame
        i_ready = 1'b0;
        i_rx = 1'b0;
        repeat (2 * DIV) @(negedge clk);
        gap(3);
        chk("glitch_count", o_count, 0);
        chk("glitch_valid", o_valid, 0);
        exp_q.push_back(mk(0, 0, 0, 8'h3C));
        send_frame(8'h3C, 0, 0, 1, 1, 0);
        gap(1);
        chk("post_glitch_count", o_count, 1);
        wait_drain();

        // break: line low 12 bit times gives exactly one word
        i_ready = 1'b0;
        exp_q.push_back(mk(1, 1, 0, 8'h00));
        i_rx = 1'b0;
        repeat (12 * BIT) @(negedge clk);
        gap(3);
        chk("brk_count", o_count, 1);
        chk("brk_flag", o_brk, 1);
        chk("brk_ferr", o_ferr, 1);
        wait_drain();

        // stop-bit checking and back-to-back frames
        i_ready = 1'b1;
        i_stop2 = 1'b1;
        exp_q.push_back(mk(0, 1, 0, 8'h5A)); send_frame(8'h5A, 0, 0, 2, 1, 0); gap(2);
        exp_q.push_back(mk(0, 0, 0, 8'hC3)); send_frame(8'hC3, 0, 0, 2, 1, 1); gap(1);
        i_stop2 = 1'b0;
        exp_q.push_back(mk(0, 1, 0, 8'hF0)); send_frame(8'hF0, 0, 0, 1, 0, 0); gap(2);
        exp_q.push_back(mk(0, 0, 0, 8'h11)); send_frame(8'h11, 0, 0, 1, 1, 0);
        exp_q.push_back(mk(0, 0, 0, 8'h22)); send_frame(8'h22, 0, 0, 1, 1, 0); gap(1);
        wait_drain();

        // overflow: 17 frames into a 16-deep FIFO
        i_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(mk(0, 0, 0, 8'(8'h40 + i)));
            send_frame(8'(8'h40 + i), 0, 0, 1, 1, 0);
        end
        gap(2);
        chk("ovf_count", o_count, 16);
        chk("ovf_flag", o_overrun, 1);
        chk("ovf_head", o_data, 8'h40);
        i_clr_overrun = 1'b1;
        @(negedge clk);
        i_clr_overrun = 1'b0;
        @(negedge clk);
        chk("ovf_clear", o_overrun, 0);
        wait_drain();

        // reset in the middle of the data bits aborts the frame
        i_ready = 1'b0;
        i_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        i_rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        i_rx = 1'b0;
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b1;
        i_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        gap(12);
        chk("rstmid_valid", o_valid, 0);
        chk("rstmid_count", o_count, 0);

        chk("sb_final", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
